// File: rtl/codec_capture.sv
// rtl/codec_capture.sv - ac97 record-sample capture FIFO with valid/ready output and overflow reporting.
// Optional: CODEC_CAPTURE_OVERFLOW_COUNT_EN implements the saturating overflow_count (tied to 0 otherwise).
module codec_capture #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     new_frame,
  input  logic [WIDTH-1:0]         codec_sample_in,
  output logic [WIDTH-1:0]         sample_out,
  output logic                     sample_valid,
  input  logic                     sample_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  input  logic                     clear_overflow,
  output logic                     overflow,
  output logic [15:0]              overflow_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] last_q;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count_q;
  logic             prev_new_frame;
  logic             overflow_q;
  logic             capture, pop, full, push, drop;

  assign capture = new_frame & ~prev_new_frame;
  assign full    = (count_q == CW'(DEPTH));
  assign pop     = sample_valid & sample_ready;
  // A pop frees the slot the incoming sample needs, so a full FIFO still accepts it.
  assign push    = capture & (~full | pop);
  assign drop    = capture & full & ~pop;

  assign sample_valid = (count_q != '0);
  assign sample_out   = sample_valid ? mem[rd_ptr] : last_q;
  assign fifo_count   = count_q;
  assign overflow     = overflow_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_new_frame <= 1'b1;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count_q        <= '0;
      last_q         <= '0;
      overflow_q     <= 1'b0;
    end else begin
      prev_new_frame <= new_frame;
      if (push) begin
        mem[wr_ptr] <= codec_sample_in;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        last_q <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (drop)
        overflow_q <= 1'b1;
      else if (clear_overflow)
        overflow_q <= 1'b0;
    end
  end

`ifdef CODEC_CAPTURE_OVERFLOW_COUNT_EN
  logic [15:0] ovf_cnt_q;

  // A drop in the same cycle as a clear restarts the count at one.
  always_ff @(posedge clk) begin
    if (reset)
      ovf_cnt_q <= '0;
    else if (drop)
      ovf_cnt_q <= clear_overflow ? 16'd1 :
                   (ovf_cnt_q == 16'hFFFF) ? 16'hFFFF : ovf_cnt_q + 16'd1;
    else if (clear_overflow)
      ovf_cnt_q <= '0;
  end

  assign overflow_count = ovf_cnt_q;
`else
  assign overflow_count = 16'h0000;
`endif

endmodule

// File: tb/tb_codec_capture.sv
// tb/tb_codec_capture.sv - self-checking bench for codec_capture: vector table, corner sequences, randomized reference-model run.
module tb_codec_capture;

  localparam int DEPTH = 4;
  localparam int WIDTH = 16;
`ifdef CODEC_CAPTURE_OVERFLOW_COUNT_EN
  localparam bit OC_EN = 1'b1;
`else
  localparam bit OC_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             new_frame = 1'b1;
  logic [WIDTH-1:0] codec_sample_in = '0;
  logic [WIDTH-1:0] sample_out;
  logic             sample_valid;
  logic             sample_ready = 1'b0;
  logic [2:0]       fifo_count;
  logic             clear_overflow = 1'b0;
  logic             overflow;
  logic [15:0]      overflow_count;

  codec_capture #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .new_frame(new_frame), .codec_sample_in(codec_sample_in),
    .sample_out(sample_out), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .fifo_count(fifo_count), .clear_overflow(clear_overflow), .overflow(overflow),
    .overflow_count(overflow_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: a queue of buffered samples plus the flag/counter rules.
  logic [15:0] mq[$];
  logic        m_prev = 1'b1;
  logic [15:0] m_last = '0;
  logic        m_ovf = 1'b0;
  int          m_oc = 0;

  typedef struct {
    logic rst; logic nf; logic [15:0] data; logic rdy; logic clr;
    logic v; logic [15:0] out; int cnt; logic ovf; int oc;
  } vec_t;
  vec_t tq[$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic rst, input logic nf, input logic [15:0] data,
                            input logic rdy, input logic clr);
    logic drop;
    if (rst) begin
      mq.delete(); m_prev = 1'b1; m_last = '0; m_ovf = 1'b0; m_oc = 0;
    end else begin
      drop = 1'b0;
      if (mq.size() > 0 && rdy) m_last = mq.pop_front();
      if (nf && !m_prev) begin
        if (mq.size() < DEPTH) mq.push_back(data);
        else drop = 1'b1;
      end
      if (drop) begin
        m_ovf = 1'b1;
        m_oc  = clr ? 1 : (m_oc == 16'hFFFF ? 16'hFFFF : m_oc + 1);
      end else if (clr) begin
        m_ovf = 1'b0; m_oc = 0;
      end
      m_prev = nf;
    end
  endtask

  task automatic cyc(input logic rst, input logic nf, input logic [15:0] data,
                     input logic rdy, input logic clr);
    reset = rst; new_frame = nf; codec_sample_in = data; sample_ready = rdy; clear_overflow = clr;
    @(posedge clk);
    model_step(rst, nf, data, rdy, clr);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [15:0] out,
                            input int cnt, input logic ovf, input int oc);
    chk({tag, ".valid"}, int'(sample_valid), int'(v));
    chk({tag, ".out"}, int'(sample_out), int'(out));
    chk({tag, ".count"}, int'(fifo_count), cnt);
    chk({tag, ".overflow"}, int'(overflow), int'(ovf));
    chk({tag, ".ovf_count"}, int'(overflow_count), OC_EN ? oc : 0);
  endtask

  task automatic add(input logic rst, input logic nf, input logic [15:0] data, input logic rdy,
                     input logic clr, input logic v, input logic [15:0] out, input int cnt,
                     input logic ovf, input int oc);
    vec_t e;
    e.rst = rst; e.nf = nf; e.data = data; e.rdy = rdy; e.clr = clr;
    e.v = v; e.out = out; e.cnt = cnt; e.ovf = ovf; e.oc = oc;
    tq.push_back(e);
  endtask

  initial begin
    // rst nf data rdy clr | valid out count ovf oc
    add(1, 1, 16'h0000, 0, 0,  0, 16'h0000, 0, 0, 0);
    add(0, 1, 16'h0000, 0, 0,  0, 16'h0000, 0, 0, 0);
    add(0, 0, 16'h0000, 0, 0,  0, 16'h0000, 0, 0, 0);
    add(0, 1, 16'h1234, 0, 0,  1, 16'h1234, 1, 0, 0);
    add(0, 1, 16'h1234, 1, 0,  0, 16'h1234, 0, 0, 0);
    add(0, 0, 16'h0001, 0, 0,  0, 16'h1234, 0, 0, 0);
    add(0, 1, 16'h0001, 0, 0,  1, 16'h0001, 1, 0, 0);
    add(0, 0, 16'h0002, 0, 0,  1, 16'h0001, 1, 0, 0);
    add(0, 1, 16'h0002, 0, 0,  1, 16'h0001, 2, 0, 0);
    add(0, 0, 16'h0003, 0, 0,  1, 16'h0001, 2, 0, 0);
    add(0, 1, 16'h0003, 0, 0,  1, 16'h0001, 3, 0, 0);
    add(0, 0, 16'h0004, 0, 0,  1, 16'h0001, 3, 0, 0);
    add(0, 1, 16'h0004, 0, 0,  1, 16'h0001, 4, 0, 0);
    add(0, 0, 16'h0005, 0, 0,  1, 16'h0001, 4, 0, 0);
    add(0, 1, 16'h0005, 0, 0,  1, 16'h0001, 4, 1, 1);
    add(0, 0, 16'h0000, 1, 0,  1, 16'h0002, 3, 1, 1);
    add(0, 0, 16'h0000, 1, 0,  1, 16'h0003, 2, 1, 1);
    add(0, 0, 16'h0000, 1, 0,  1, 16'h0004, 1, 1, 1);
    add(0, 0, 16'h0000, 1, 0,  0, 16'h0004, 0, 1, 1);
    add(0, 0, 16'h0000, 0, 1,  0, 16'h0004, 0, 0, 0);

    for (int i = 0; i < tq.size(); i++) begin
      cyc(tq[i].rst, tq[i].nf, tq[i].data, tq[i].rdy, tq[i].clr);
      expect_out($sformatf("vec%0d", i), tq[i].v, tq[i].out, tq[i].cnt, tq[i].ovf, tq[i].oc);
    end

    // Full FIFO with capture coinciding with a pop.
    for (int k = 1; k <= 4; k++) begin
      cyc(0, 0, 16'(k), 0, 0);
      cyc(0, 1, 16'(k), 0, 0);
    end
    expect_out("fullpop.pre", 1, 16'h0001, 4, 0, 0);
    cyc(0, 0, 16'h0005, 0, 0);
    cyc(0, 1, 16'h0005, 1, 0);
    expect_out("fullpop.edge", 1, 16'h0002, 4, 0, 0);
    for (int k = 3; k <= 5; k++) begin
      cyc(0, 0, 16'h0000, 1, 0);
      expect_out($sformatf("fullpop.pop%0d", k), 1, 16'(k), 6 - k, 0, 0);
    end
    cyc(0, 0, 16'h0000, 1, 0);
    expect_out("fullpop.empty", 0, 16'h0005, 0, 0, 0);

    // Three drops, then clear_overflow on the same cycle as a fourth drop.
    for (int k = 1; k <= 4; k++) begin
      cyc(0, 0, 16'(k), 0, 0);
      cyc(0, 1, 16'(k), 0, 0);
    end
    for (int k = 1; k <= 3; k++) begin
      cyc(0, 0, 16'h0009, 0, 0);
      cyc(0, 1, 16'h0009, 0, 0);
      expect_out($sformatf("drop%0d", k), 1, 16'h0001, 4, 1, k);
    end
    cyc(0, 0, 16'h0009, 0, 0);
    cyc(0, 1, 16'h0009, 0, 1);
    expect_out("clr_drop", 1, 16'h0001, 4, 1, 1);
    cyc(0, 0, 16'h0000, 0, 1);
    expect_out("clr_only", 1, 16'h0001, 4, 0, 0);

    // Reset with three samples buffered, then a normal capture.
    cyc(0, 0, 16'h0000, 1, 0);
    expect_out("rst.pre", 1, 16'h0002, 3, 0, 0);
    cyc(1, 0, 16'h0000, 0, 0);
    expect_out("rst.flush", 0, 16'h0000, 0, 0, 0);
    cyc(0, 0, 16'h0077, 0, 0);
    expect_out("rst.idle", 0, 16'h0000, 0, 0, 0);
    cyc(0, 1, 16'h0077, 0, 0);
    expect_out("rst.cap", 1, 16'h0077, 1, 0, 0);
    cyc(0, 1, 16'h0088, 0, 0);
    expect_out("rst.hold", 1, 16'h0077, 1, 0, 0);

    // Randomized run against the queue model.
    begin
      logic nf_r = 1'b1;
      for (int i = 0; i < 3000; i++) begin
        logic rst_r, rdy_r, clr_r;
        logic [15:0] d_r;
        if ($urandom_range(0, 2) == 0) nf_r = ~nf_r;
        rdy_r = ($urandom_range(0, 3) == 0);
        clr_r = ($urandom_range(0, 19) == 0);
        rst_r = ($urandom_range(0, 299) == 0);
        d_r   = 16'($urandom);
        cyc(rst_r, nf_r, d_r, rdy_r, clr_r);
        expect_out($sformatf("rand%0d", i), mq.size() > 0,
                   mq.size() > 0 ? mq[0] : m_last, mq.size(), m_ovf, m_oc);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/codec_capture.md
# codec_capture

Receive-side counterpart to the playback path: accepts ADC samples from the ac97 codec and delivers them to the system. On each rising edge of the codec's new_frame it captures the 16-bit record sample, pushes it into a small FIFO, and presents the samples with a valid/ready handshake. Overflow is detected and reported, so a slow consumer never corrupts buffered data.

## Interface
Parameters:
- DEPTH, 4 — FIFO entries; power of two, ≥2.
- WIDTH, 16 — sample width in bits.

Ports:
- clk  in  1  system clock (100 MHz).
- reset  in  1  synchronous, active-high reset.
- new_frame  in  1  from codec; high while the codec frame is active; codec_sample_in is stable while high.
- codec_sample_in  in  WIDTH  record sample from codec.
- sample_out  out  WIDTH  FIFO head sample.
- sample_valid  out  1  high when the FIFO is non-empty.
- sample_ready  in  1  consumer accepts sample_out this cycle.
- fifo_count  out  $clog2(DEPTH)+1  current occupancy.
- clear_overflow  in  1  clears the sticky overflow flag and overflow_count.
- overflow  out  1  sticky; a sample was dropped.
- overflow_count  out  16  saturating count of dropped samples.

## Operation
- Edge detect: prev_new_frame register, with d = new_frame.
  - capture = new_frame && ~prev_new_frame; exactly one cycle per frame.
- prev_new_frame resets to 1, so a frame already high at reset release is not captured. Capture begins at the next rising edge.
- Push: on capture, codec_sample_in is written at the write pointer, and the write pointer increments modulo DEPTH.
- Pop: sample_valid && sample_ready; the read pointer increments modulo DEPTH.
- Occupancy: fifo_count = +1 on push only, −1 on pop only, unchanged on push+pop.
- Full (fifo_count == DEPTH) with capture:
  - With a pop in the same cycle: push accepted, count stays DEPTH, no overflow.
  - Without a pop: the new sample is dropped, buffered data is unchanged, overflow is set to 1, and overflow_count increments, saturating at 16'hFFFF.
- Empty with capture: pop is impossible that cycle (sample_valid = 0). The sample becomes visible the next cycle.
- clear_overflow:
  - Clears overflow and overflow_count next cycle.
  - If it coincides with a drop, the drop wins: overflow = 1, overflow_count = 1.
- sample_ready while sample_valid = 0 is ignored.
- sample_out is undefined-but-stable garbage-free: it shows the head entry, or the last popped value when empty; consumers qualify it with sample_valid.

## Timing
- Reset values: sample_valid 0, fifo_count 0, overflow 0, overflow_count 0, sample_out 0, pointers 0, prev_new_frame 1.
- Capture latency: new_frame rises with edge seen at cycle N → sample written at the end of N → sample_valid = 1 and sample_out valid in cycle N+1.
- Handshake: a sample transfers on any cycle with sample_valid && sample_ready. sample_out and sample_valid change only on clock edges and do not depend combinationally on sample_ready.
- Throughput: one pop per cycle. At most one push per frame (~2083 cycles at 48 kHz).
- Reset asserted mid-operation: all buffered samples are discarded at the next edge. No capture occurs while reset = 1.

## Configuration
- CODEC_CAPTURE_OVERFLOW_COUNT_EN:
  - Defined: overflow_count is implemented as above.
  - Undefined: the counter logic is omitted and overflow_count is tied to 0. The overflow flag and drop behaviour are unchanged.

## Test plan
- Reset release with new_frame = 1, then new_frame falls and rises with codec_sample_in = 16'h1234:
  - No capture at release.
  - Exactly one push: sample_valid = 1 one cycle after the edge, sample_out = 16'h1234, fifo_count = 1.
- Four frames (samples 1, 2, 3, 4) with sample_ready = 0, then sample_ready = 1: pops in order 1, 2, 3, 4 on consecutive cycles, sample_valid = 0 after the fourth.
- With the FIFO full (1–4) and sample_ready = 0, a fifth frame with sample 5:
  - Dropped; overflow = 1, overflow_count = 1.
  - Pops yield 1–4.
  - With the macro undefined, overflow_count stays 0.
- FIFO full, capture edge coinciding with a pop: 1 is popped, 5 is accepted, fifo_count stays 4, overflow stays 0; later pops are 2, 3, 4, 5.
- After overflow_count = 3, clear_overflow coinciding with a drop: overflow = 1, overflow_count = 1. A lone clear_overflow next gives 0/0.
- Reset asserted with fifo_count = 3: next cycle fifo_count = 0 and sample_valid = 0; a subsequent frame gives normal single-sample capture.
